mac_neuron_pipe: RTL and testbench

//  Parametrised, pipelined signed multiply-accumulate unit: successor to the combinational signed multiplier.

---
 rtl/mac_pkg.sv | 32 +++
 rtl/mac_sat_shift.sv | 23 ++
 rtl/mac_neuron_pipe.sv | 102 ++++++++++
 tb/tb_mac_neuron_pipe.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared helpers for the MAC neuron: output range limits and the floor-shift/saturate step.
// Widths up to 64 bits are handled in one wide signed type and narrowed by the caller.
package mac_pkg;

  localparam int SAT_W = 64;

  typedef logic signed [SAT_W-1:0] wide_t;

  function automatic wide_t out_max(input int out_w);
    return (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t out_min(input int out_w);
    return -(wide_t'(1) <<< (out_w - 1));
  endfunction

  // Arithmetic shift floors toward minus infinity, matching the fixed-point scaling.
  function automatic wide_t sat_shift(input wide_t acc, input int frac, input int out_w);
    wide_t shifted;
    shifted = acc >>> frac;
    if (shifted > out_max(out_w)) return out_max(out_w);
    if (shifted < out_min(out_w)) return out_min(out_w);
    return shifted;
  endfunction

  function automatic logic sat_clipped(input wide_t acc, input int frac, input int out_w);
    wide_t shifted;
    shifted = acc >>> frac;
    return (shifted > out_max(out_w)) || (shifted < out_min(out_w));
  endfunction

endpackage

// File: rtl/mac_sat_shift.sv
// Combinational shift-and-saturate of a signed accumulator into the signed output width.
module mac_sat_shift
  import mac_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [OUT_WIDTH-1:0] data,
  output logic                 sat
);

  wide_t acc_wide;

  // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
  always_comb begin
    acc_wide = wide_t'(signed'(acc));
    data     = OUT_WIDTH'(sat_shift(acc_wide, FRAC_BITS, OUT_WIDTH));
    sat      = sat_clipped(acc_wide, FRAC_BITS, OUT_WIDTH);
  end

endmodule

// File: rtl/mac_neuron_pipe.sv
// Two-stage pipelined signed multiply-accumulate neuron: product stage, then accumulate with
// per-vector bias, emitting one shifted and saturated result per vector over valid/ready.
module mac_neuron_pipe
  import mac_pkg::*;
#(
  parameter int INP_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [ACC_WIDTH-1:0] bias,
  input  logic [INP_WIDTH-1:0] a,
  input  logic [INP_WIDTH-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat
);

  localparam int PROD_WIDTH = 2 * INP_WIDTH;

  if (ACC_WIDTH < PROD_WIDTH || ACC_WIDTH > SAT_W) begin : g_bad_acc_width
    $error("mac_neuron_pipe: ACC_WIDTH must lie in [2*INP_WIDTH, 64]");
  end

  logic                         stall;
  logic                         accept;
  logic                         first_flag;
  logic signed [PROD_WIDTH-1:0] prod;

  logic                         p_valid;
  logic                         p_last;
  logic                         p_first;
  logic signed [PROD_WIDTH-1:0] p_prod;
  logic signed [ACC_WIDTH-1:0]  p_bias;

  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic [OUT_WIDTH-1:0]         res_data;
  logic                         res_sat;

  // A held result freezes the whole pipe, so nothing upstream can overwrite it.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  assign prod = PROD_WIDTH'(signed'(a)) * PROD_WIDTH'(signed'(b));
  assign sum  = (p_first ? p_bias : acc) + ACC_WIDTH'(p_prod);

  mac_sat_shift #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat_shift (
    .acc  (sum),
    .data (res_data),
    .sat  (res_sat)
  );

  // NOTE: non-blocking assignments make every stage read the pre-edge value of the stage before it.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_flag <= 1'b1;
      p_valid    <= 1'b0;
      p_last     <= 1'b0;
      p_first    <= 1'b0;
      p_prod     <= '0;
      p_bias     <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
    end else if (!stall) begin
      p_valid <= accept;
      if (accept) begin
        p_prod     <= prod;
        p_last     <= in_last;
        p_first    <= first_flag;
        first_flag <= in_last;
        if (first_flag) p_bias <= bias;
      end

      // Not stalled means any current result is being taken, so only a fresh load keeps it high.
      out_valid <= p_valid & p_last;
      if (p_valid) begin
        if (p_last) begin
          acc      <= '0;
          out_data <= res_data;
          out_sat  <= res_sat;
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_neuron_pipe.sv
// Self-checking bench for mac_neuron_pipe: directed scenarios plus randomized vectors,
// all results compared against a plain-arithmetic dot-product model.
module tb_mac_neuron_pipe;

  localparam int INP = 8;
  localparam int ACC = 32;
  localparam int OUT = 16;
  localparam int FRAC = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic signed [ACC-1:0] bias;
  logic signed [INP-1:0] a;
  logic signed [INP-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [OUT-1:0] out_data;
  logic                  out_sat;

  mac_neuron_pipe #(
    .INP_WIDTH (INP),
    .ACC_WIDTH (ACC),
    .OUT_WIDTH (OUT),
    .FRAC_BITS (FRAC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .bias      (bias),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: exact dot product, wrapped to ACC bits, floor-divided, clipped.
  typedef struct {
    longint data;
    bit     sat;
  } res_t;

  function automatic res_t model_result(input longint s);
    longint w, q, scale, hi, lo;
    res_t   r;
    scale = longint'(1) << FRAC;
    hi    = (longint'(1) << (OUT - 1)) - 1;
    lo    = -(longint'(1) << (OUT - 1));
    w     = longint'(int'(s));
    q     = (w - (((w % scale) + scale) % scale)) / scale;
    if (q > hi)      r = '{hi, 1'b1};
    else if (q < lo) r = '{lo, 1'b1};
    else             r = '{q, 1'b0};
    return r;
  endfunction

  res_t   exp_q[$];
  longint model_sum   = 0;
  bit     model_first = 1'b1;

  int     cycle     = 0;
  int     n_results = 0;
  longint last_data = 0;
  longint last_sat  = 0;
  bit     rec_hs    = 1'b0;
  int     hs_cyc[$];
  bit     prev_stall = 1'b0;
  logic signed [OUT-1:0] prev_data = '0;
  bit     rand_ready = 1'b0;

  // Single compare process: output handshakes, stall stability, ready rule, then model update.
  always @(negedge clk) begin
    res_t e;
    cycle++;
    if (rst) begin
      exp_q.delete();
      model_sum   = 0;
      model_first = 1'b1;
      prev_stall  = 1'b0;
    end else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("held out_valid", out_valid, 1);
        check("held out_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious result", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_sat", out_sat, e.sat);
        end
        n_results++;
        last_data = out_data;
        last_sat  = out_sat;
        if (rec_hs) hs_cyc.push_back(cycle);
      end
      if (in_valid && in_ready) begin
        if (model_first) model_sum = longint'(bias);
        model_sum  += longint'(a) * longint'(b);
        model_first = in_last;
        if (in_last) begin
          exp_q.push_back(model_result(model_sum));
          model_sum = 0;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Must be called just after a rising edge; returns just after the edge that took the beat.
  task automatic send_beat(input logic signed [ACC-1:0] bv, input logic signed [INP-1:0] av,
                           input logic signed [INP-1:0] bv2, input bit last);
    bit took;
    int budget;
    in_valid = 1'b1;
    bias     = bv;
    a        = av;
    b        = bv2;
    in_last  = last;
    budget   = 0;
    took     = 1'b0;
    while (!took && budget < 1000) begin
      @(negedge clk);
      took = in_ready;
      step();
      budget++;
    end
    if (!took) check("beat accept timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || out_valid) && budget < 3000) begin
      step();
      budget++;
    end
    check("drain pending", exp_q.size(), 0);
  endtask

  initial begin
    res_t pin;
    int   base;
    int   len;
    int   bv_wait;
    logic signed [ACC-1:0] vb;
    logic signed [INP-1:0] va, vb2;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; bias = '0; a = '0; b = '0; out_ready = 1'b1;

    // Model pinned to hand-computed values.
    pin = model_result(64516);    check("model 64516", pin.data, 252);
    pin = model_result(255);      check("model 255", pin.data, 0);
    pin = model_result(-1);       check("model -1", pin.data, -1);
    pin = model_result(9677400);  check("model pos sat", pin.data, 32767);
    check("model pos sat flag", pin.sat, 1);
    pin = model_result(-9753600); check("model neg sat", pin.data, -32768);

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_sat", out_sat, 0);
    check("reset in_ready", in_ready, 1);
    step();

    // 1: four beats of 127*127, latency two cycles after the last beat.
    for (int k = 0; k < 4; k++) send_beat(0, 127, 127, k == 3);
    @(negedge clk); check("t1 out_valid N+1", out_valid, 0);
    @(negedge clk); check("t1 out_valid N+2", out_valid, 1);
    check("t1 out_data", out_data, 252);
    check("t1 out_sat", out_sat, 0);
    step();
    drain();

    // 2: positive and negative saturation.
    for (int k = 0; k < 600; k++) send_beat(0, 127, 127, k == 599);
    drain();
    check("t2 pos data", last_data, 32767);
    check("t2 pos sat", last_sat, 1);
    for (int k = 0; k < 600; k++) send_beat(0, -128, 127, k == 599);
    drain();
    check("t2 neg data", last_data, -32768);
    check("t2 neg sat", last_sat, 1);

    // 3: single-beat vectors showing the floor behaviour.
    send_beat(256, -1, 1, 1'b1);
    drain();
    check("t3 floor 255", last_data, 0);
    send_beat(-1, 0, 0, 1'b1);
    drain();
    check("t3 floor -1", last_data, -1);
    send_beat(0, -128, -128, 1'b1);
    drain();
    check("t3 extreme product", last_data, 64);

    // 4: consumer back-pressure with a result pending.
    out_ready = 1'b0;
    send_beat(1000, 100, 50, 1'b0);
    send_beat(7, 100, 50, 1'b1);
    bv_wait = 0;
    @(negedge clk);
    while (!out_valid && bv_wait < 20) begin
      @(negedge clk);
      bv_wait++;
    end
    check("t4 result appeared", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("t4 in_ready low", in_ready, 0);
      check("t4 out_data stable", out_data, 42);
      @(negedge clk);
    end
    step();
    out_ready = 1'b1;
    drain();
    check("t4 released data", last_data, 42);
    send_beat(0, 16, 16, 1'b1);
    drain();
    check("t4 next vector", last_data, 1);

    // 5: reset mid-vector discards the partial sum.
    send_beat(0, 10, 10, 1'b0);
    send_beat(0, 10, 10, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    base = n_results;
    send_beat(0, 16, 16, 1'b1);
    drain();
    repeat (5) step();
    check("t5 result count", n_results - base, 1);
    check("t5 out_data", last_data, 1);

    // 6: back-to-back 3-beat vectors with no bubbles.
    hs_cyc.delete();
    rec_hs = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 3; k++) begin
        vb  = ACC'(int'($urandom_range(0, 2000)) - 1000);
        va  = INP'($urandom);
        vb2 = INP'($urandom);
        send_beat(vb, va, vb2, k == 2);
      end
    end
    drain();
    rec_hs = 1'b0;
    check("t6 result count", hs_cyc.size(), 4);
    for (int i = 1; i < hs_cyc.size(); i++) check("t6 spacing", hs_cyc[i] - hs_cyc[i-1], 3);

    // Randomized vectors, gaps and back-pressure.
    rand_ready = 1'b1;
    for (int v = 0; v < 250; v++) begin
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) vb = ACC'($urandom);
        else vb = ACC'(int'($urandom_range(0, 10000)) - 5000);
        if ($urandom_range(0, 7) == 0) begin
          va  = -128;
          vb2 = ($urandom_range(0, 1) == 1) ? -128 : 127;
        end else begin
          va  = INP'($urandom);
          vb2 = INP'($urandom);
        end
        send_beat(vb, va, vb2, k == len - 1);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
      end
    end
    rand_ready = 1'b0;
    step();
    out_ready = 1'b1;
    drain();
    check("final queue empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
